// File: rtl/fpmul_arbiter_if.sv
// Bus bundle between the requesters/multiplier side and fpmul_arbiter.
//
// Handshake: a transfer on requester X happens on a rising edge where
// X_valid and X_ready are both high. X_ready may depend combinationally on
// X_valid, so a requester must hold X_valid and its operands stable until it
// sees X_ready. Results carry no backpressure: res_valid_X is a one-cycle
// pulse and res_data must be taken in that cycle.
interface fpmul_arbiter_if;
  logic        a_valid;
  logic [31:0] a_opa;
  logic [31:0] a_opb;
  logic        a_ready;
  logic        b_valid;
  logic [31:0] b_opa;
  logic [31:0] b_opb;
  logic        b_ready;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_z;
  logic [31:0] res_data;
  logic        res_valid_a;
  logic        res_valid_b;

  // Requesters plus the attached multiplier's FP_Z pin.
  modport master (
    output a_valid, a_opa, a_opb, b_valid, b_opa, b_opb, mul_z,
    input  a_ready, b_ready, mul_a, mul_b, res_data, res_valid_a, res_valid_b
  );

  // The arbiter itself.
  modport slave (
    input  a_valid, a_opa, a_opb, b_valid, b_opa, b_opb, mul_z,
    output a_ready, b_ready, mul_a, mul_b, res_data, res_valid_a, res_valid_b
  );
endinterface

// File: rtl/fpmul_arbiter.sv
// Round-robin scheduler sharing one fixed-latency pipelined FP multiplier
// between requesters A and B. Each issue pushes a tag down a LAT-deep shift
// register that runs in lockstep with the multiplier, so the product on
// mul_z is steered back to the requester that issued it.
module fpmul_arbiter #(
  parameter int LAT = 4,
  parameter int CW  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  fpmul_arbiter_if.slave           bus,
  output logic [$clog2(LAT+1)-1:0] inflight,
  output logic                     idle,
  output logic [CW-1:0]            done_cnt_a,
  output logic [CW-1:0]            done_cnt_b
);
  localparam int IW = $clog2(LAT+1);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  prio_e          r_prio;
  logic [31:0]    r_mul_a;
  logic [31:0]    r_mul_b;
  logic [LAT-1:0] r_tag_vld;
  logic [LAT-1:0] r_tag_id;   // 0 = A, 1 = B
  logic           r_res_a;
  logic           r_res_b;
  logic [IW-1:0]  r_inflight;
  logic [CW-1:0]  r_cnt_a;
  logic [CW-1:0]  r_cnt_b;

  logic           w_grant_a;
  logic           w_grant_b;
  logic           w_issue;
  logic           w_ret;
  logic           w_ret_a;
  logic           w_ret_b;

  // Combinational grant: lone requester always wins, a tie goes to r_prio.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (!rst) begin
      w_grant_a = bus.a_valid & (~bus.b_valid | (r_prio == PRIO_A));
      w_grant_b = bus.b_valid & (~bus.a_valid | (r_prio == PRIO_B));
    end
  end

  assign w_issue = w_grant_a | w_grant_b;

  // The tag in the last stage is the op whose product appears on mul_z
  // after the coming edge; the result flags are registered from it.
  assign w_ret   = r_tag_vld[LAT-1];
  assign w_ret_a = w_ret & ~r_tag_id[LAT-1];
  assign w_ret_b = w_ret &  r_tag_id[LAT-1];

  // Priority pointer flips to the other requester after every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= PRIO_A;
    end else if (w_grant_a) begin
      r_prio <= PRIO_B;
    end else if (w_grant_b) begin
      r_prio <= PRIO_A;
    end
  end

  // Operand registers feeding FP_A/FP_B; they hold when nothing issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_a <= '0;
      r_mul_b <= '0;
    end else if (w_grant_a) begin
      r_mul_a <= bus.a_opa;
      r_mul_b <= bus.a_opb;
    end else if (w_grant_b) begin
      r_mul_a <= bus.b_opa;
      r_mul_b <= bus.b_opb;
    end
  end

  // Tag shift register tracking the multiplier pipeline, plus result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
      r_res_a   <= 1'b0;
      r_res_b   <= 1'b0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
      r_tag_vld[0] <= w_issue;
      r_tag_id[0]  <= w_grant_b;
      r_res_a      <= w_ret_a;
      r_res_b      <= w_ret_b;
    end
  end

  // Outstanding-op count; the decrement lands on the edge that raises the
  // result flag, so the count never exceeds LAT under full throughput.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
    end else if (w_issue && !w_ret) begin
      r_inflight <= r_inflight + IW'(1);
    end else if (!w_issue && w_ret) begin
      r_inflight <= r_inflight - IW'(1);
    end
  end

  // Per-requester completion counters, wrapping naturally at 2^CW.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      if (w_ret_a) r_cnt_a <= r_cnt_a + CW'(1);
      if (w_ret_b) r_cnt_b <= r_cnt_b + CW'(1);
    end
  end

  assign bus.a_ready     = w_grant_a;
  assign bus.b_ready     = w_grant_b;
  assign bus.mul_a       = r_mul_a;
  assign bus.mul_b       = r_mul_b;
  assign bus.res_data    = bus.mul_z;
  assign bus.res_valid_a = r_res_a;
  assign bus.res_valid_b = r_res_b;
  assign inflight        = r_inflight;
  assign idle            = (r_inflight == '0);
  assign done_cnt_a      = r_cnt_a;
  assign done_cnt_b      = r_cnt_b;
endmodule

// File: tb/tb_fpmul_arbiter.sv
// Directed bench for fpmul_arbiter with a LAT-deep multiplier model whose
// products come from a table of hand-computed IEEE-754 single products.
// A second instance with CW=2 mirrors the same traffic to exercise wrap.
module tb_fpmul_arbiter;
  localparam int LAT = 4;
  localparam int CW  = 16;
  localparam int IW  = $clog2(LAT + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpmul_arbiter_if bus();
  fpmul_arbiter_if bus2();

  logic [IW-1:0] inflight, inflight2;
  logic          idle, idle2;
  logic [CW-1:0] done_cnt_a, done_cnt_b;
  logic [1:0]    done2_a, done2_b;

  int checks   = 0;
  int failures = 0;

  fpmul_arbiter #(.LAT(LAT), .CW(CW)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .inflight(inflight), .idle(idle),
    .done_cnt_a(done_cnt_a), .done_cnt_b(done_cnt_b)
  );

  fpmul_arbiter #(.LAT(LAT), .CW(2)) u_dut_wrap (
    .clk(clk), .rst(rst), .bus(bus2), .inflight(inflight2), .idle(idle2),
    .done_cnt_a(done2_a), .done_cnt_b(done2_b)
  );

  assign bus2.a_valid = bus.a_valid;
  assign bus2.a_opa   = bus.a_opa;
  assign bus2.a_opb   = bus.a_opb;
  assign bus2.b_valid = bus.b_valid;
  assign bus2.b_opa   = bus.b_opa;
  assign bus2.b_opb   = bus.b_opb;
  assign bus2.mul_z   = bus.mul_z;

  // Hand-computed products for the operand pairs used below.
  function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40000000, 32'h40400000}: fp_ref = 32'h40C00000; // 2.0 * 3.0 = 6.0
      {32'h3FC00000, 32'h40000000}: fp_ref = 32'h40400000; // 1.5 * 2.0 = 3.0
      {32'h40800000, 32'h3F000000}: fp_ref = 32'h40000000; // 4.0 * 0.5 = 2.0
      {32'hBF800000, 32'h40000000}: fp_ref = 32'hC0000000; // -1.0 * 2.0 = -2.0
      {32'h40400000, 32'h40400000}: fp_ref = 32'h41100000; // 3.0 * 3.0 = 9.0
      {32'h3F800000, 32'h40A00000}: fp_ref = 32'h40A00000; // 1.0 * 5.0 = 5.0
      default:                      fp_ref = 32'h00000000;
    endcase
  endfunction

  // Multiplier model: FP_Z is valid LAT edges after the operand registers.
  logic [31:0] m_pipe [LAT];
  always_ff @(posedge clk) begin
    m_pipe[0] <= fp_ref(bus.mul_a, bus.mul_b);
    for (int i = 1; i < LAT; i++) m_pipe[i] <= m_pipe[i-1];
  end
  assign bus.mul_z = m_pipe[LAT-1];

  task automatic drive_quiet();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_quiet();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.a_opa = 32'h40000000; bus.a_opb = 32'h40400000;
    bus.b_opa = 32'h40800000; bus.b_opb = 32'h3F000000;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.a_ready !== 1'b0) begin failures++; $display("FAIL rst_a_ready got=%b exp=0", bus.a_ready); end
    checks++; if (bus.b_ready !== 1'b0) begin failures++; $display("FAIL rst_b_ready got=%b exp=0", bus.b_ready); end
    checks++; if (bus.mul_a !== 32'h0) begin failures++; $display("FAIL rst_mul_a got=%h exp=0", bus.mul_a); end
    checks++; if (bus.mul_b !== 32'h0) begin failures++; $display("FAIL rst_mul_b got=%h exp=0", bus.mul_b); end
    checks++; if ({bus.res_valid_a, bus.res_valid_b} !== 2'b00) begin failures++; $display("FAIL rst_res_valid got=%b exp=00", {bus.res_valid_a, bus.res_valid_b}); end
    checks++; if (inflight !== '0) begin failures++; $display("FAIL rst_inflight got=%0d exp=0", inflight); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle got=%b exp=1", idle); end
    checks++; if (done_cnt_a !== '0 || done_cnt_b !== '0) begin failures++; $display("FAIL rst_done got=%0d/%0d exp=0/0", done_cnt_a, done_cnt_b); end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_quiet();
  endtask

  task automatic test_single_a();
    do_reset();
    bus.a_opa = 32'h40000000; bus.a_opb = 32'h40400000;
    bus.a_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus.a_ready !== 1'b1) begin failures++; $display("FAIL single_a_ready got=%b exp=1", bus.a_ready); end
    checks++; if (bus.b_ready !== 1'b0) begin failures++; $display("FAIL single_b_ready got=%b exp=0", bus.b_ready); end
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    @(negedge clk);
    checks++; if ({bus.mul_a, bus.mul_b} !== {32'h40000000, 32'h40400000}) begin failures++; $display("FAIL single_mul_ops got=%h_%h exp=40000000_40400000", bus.mul_a, bus.mul_b); end
    checks++; if (inflight !== IW'(1) || idle !== 1'b0) begin failures++; $display("FAIL single_inflight1 got=%0d idle=%b exp=1 idle=0", inflight, idle); end
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (bus.res_valid_a !== (n == 4)) begin failures++; $display("FAIL single_res_valid_a n=%0d got=%b exp=%b", n, bus.res_valid_a, (n == 4)); end
      if (n == 3) begin
        checks++; if (inflight !== IW'(1)) begin failures++; $display("FAIL single_inflight_n3 got=%0d exp=1", inflight); end
      end
      if (n == 4) begin
        checks++; if (bus.res_data !== 32'h40C00000) begin failures++; $display("FAIL single_res_data got=%h exp=40c00000", bus.res_data); end
        checks++; if (inflight !== '0 || idle !== 1'b1) begin failures++; $display("FAIL single_inflight0 got=%0d idle=%b exp=0 idle=1", inflight, idle); end
      end
    end
    checks++; if (done_cnt_a !== CW'(1)) begin failures++; $display("FAIL single_done_a got=%0d exp=1", done_cnt_a); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.a_opa = 32'h3FC00000; bus.a_opb = 32'h40000000;
    bus.b_opa = 32'h40800000; bus.b_opb = 32'h3F000000;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      logic exp_ga, exp_gb, exp_ra, exp_rb;
      @(negedge clk);
      exp_ga = (c < 8) && (c % 2 == 0);
      exp_gb = (c < 8) && (c % 2 == 1);
      exp_ra = (c >= 5) && (c <= 12) && ((c - 5) % 2 == 0);
      exp_rb = (c >= 5) && (c <= 12) && ((c - 5) % 2 == 1);
      checks++; if ({bus.a_ready, bus.b_ready} !== {exp_ga, exp_gb}) begin failures++; $display("FAIL alt_grant c=%0d got=%b exp=%b", c, {bus.a_ready, bus.b_ready}, {exp_ga, exp_gb}); end
      checks++; if ({bus.res_valid_a, bus.res_valid_b} !== {exp_ra, exp_rb}) begin failures++; $display("FAIL alt_return c=%0d got=%b exp=%b", c, {bus.res_valid_a, bus.res_valid_b}, {exp_ra, exp_rb}); end
      if (exp_ra) begin
        checks++; if (bus.res_data !== 32'h40400000) begin failures++; $display("FAIL alt_data_a c=%0d got=%h exp=40400000", c, bus.res_data); end
      end
      if (exp_rb) begin
        checks++; if (bus.res_data !== 32'h40000000) begin failures++; $display("FAIL alt_data_b c=%0d got=%h exp=40000000", c, bus.res_data); end
      end
      if (c == 4) begin
        checks++; if (inflight !== IW'(LAT)) begin failures++; $display("FAIL alt_inflight_full got=%0d exp=%0d", inflight, LAT); end
      end
      @(posedge clk); #1;
      if (c == 7) drive_quiet();
    end
    checks++; if (done_cnt_a !== CW'(4) || done_cnt_b !== CW'(4)) begin failures++; $display("FAIL alt_done got=%0d/%0d exp=4/4", done_cnt_a, done_cnt_b); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL alt_idle got=%b exp=1", idle); end
  endtask

  task automatic test_b_only();
    int max_inf;
    do_reset();
    max_inf = 0;
    bus.b_opa = 32'hBF800000; bus.b_opb = 32'h40000000;
    bus.b_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      logic exp_rb;
      @(negedge clk);
      exp_rb = (c >= 5) && (c <= 10);
      checks++; if ({bus.a_ready, bus.b_ready} !== {1'b0, (c < 6)}) begin failures++; $display("FAIL bonly_grant c=%0d got=%b exp=0%b", c, {bus.a_ready, bus.b_ready}, (c < 6)); end
      checks++; if ({bus.res_valid_a, bus.res_valid_b} !== {1'b0, exp_rb}) begin failures++; $display("FAIL bonly_return c=%0d got=%b exp=0%b", c, {bus.res_valid_a, bus.res_valid_b}, exp_rb); end
      if (exp_rb) begin
        checks++; if (bus.res_data !== 32'hC0000000) begin failures++; $display("FAIL bonly_data c=%0d got=%h exp=c0000000", c, bus.res_data); end
      end
      if (int'(inflight) > max_inf) max_inf = int'(inflight);
      @(posedge clk); #1;
      if (c == 5) drive_quiet();
    end
    checks++; if (max_inf != LAT) begin failures++; $display("FAIL bonly_inflight_peak got=%0d exp=%0d", max_inf, LAT); end
    checks++; if (done_cnt_b !== CW'(6) || done_cnt_a !== '0) begin failures++; $display("FAIL bonly_done got=%0d/%0d exp=0/6", done_cnt_a, done_cnt_b); end
  endtask

  task automatic test_gap();
    do_reset();
    bus.a_opa = 32'h40400000; bus.a_opb = 32'h40400000;
    bus.b_opa = 32'h3F800000; bus.b_opb = 32'h40A00000;
    bus.a_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++; if ({bus.a_ready, bus.b_ready} !== {(c == 0), (c == 3)}) begin failures++; $display("FAIL gap_grant c=%0d got=%b exp=%b", c, {bus.a_ready, bus.b_ready}, {(c == 0), (c == 3)}); end
      checks++; if ({bus.res_valid_a, bus.res_valid_b} !== {(c == 5), (c == 8)}) begin failures++; $display("FAIL gap_return c=%0d got=%b exp=%b", c, {bus.res_valid_a, bus.res_valid_b}, {(c == 5), (c == 8)}); end
      if (c == 5) begin
        checks++; if (bus.res_data !== 32'h41100000) begin failures++; $display("FAIL gap_data_a got=%h exp=41100000", bus.res_data); end
      end
      if (c == 8) begin
        checks++; if (bus.res_data !== 32'h40A00000) begin failures++; $display("FAIL gap_data_b got=%h exp=40a00000", bus.res_data); end
      end
      @(posedge clk); #1;
      if (c == 0) bus.a_valid = 1'b0;
      if (c == 2) bus.b_valid = 1'b1;
      if (c == 3) bus.b_valid = 1'b0;
    end
  endtask

  task automatic test_reset_midflight();
    int pulses;
    do_reset();
    bus.a_opa = 32'h40000000; bus.a_opb = 32'h40400000;
    bus.b_opa = 32'h40800000; bus.b_opb = 32'h3F000000;
    bus.a_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.a_valid = 1'b0;
    @(negedge clk);
    checks++; if (inflight !== IW'(3)) begin failures++; $display("FAIL mid_inflight_before got=%0d exp=3", inflight); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (inflight !== '0 || idle !== 1'b1) begin failures++; $display("FAIL mid_inflight_after got=%0d idle=%b exp=0 idle=1", inflight, idle); end
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.res_valid_a === 1'b1 || bus.res_valid_b === 1'b1) pulses++;
      @(posedge clk);
      @(negedge clk);
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL mid_stale_pulses got=%0d exp=0", pulses); end
    checks++; if (done_cnt_a !== '0) begin failures++; $display("FAIL mid_done_a got=%0d exp=0", done_cnt_a); end
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    #1;
    checks++; if ({bus.a_ready, bus.b_ready} !== 2'b10) begin failures++; $display("FAIL mid_prio_after_rst got=%b exp=10", {bus.a_ready, bus.b_ready}); end
    @(posedge clk); #1;
    drive_quiet();
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++; if (done_cnt_a !== CW'(1) || done_cnt_b !== '0) begin failures++; $display("FAIL mid_done_after got=%0d/%0d exp=1/0", done_cnt_a, done_cnt_b); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.a_opa = 32'h40000000; bus.a_opb = 32'h40400000;
    bus.a_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.a_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++; if (done_cnt_a !== CW'(5)) begin failures++; $display("FAIL wrap_wide_done_a got=%0d exp=5", done_cnt_a); end
    checks++; if (done2_a !== 2'd1) begin failures++; $display("FAIL wrap_done_a got=%0d exp=1", done2_a); end
    checks++; if (done2_b !== 2'd0) begin failures++; $display("FAIL wrap_done_b got=%0d exp=0", done2_b); end
    checks++; if (inflight2 !== '0 || idle2 !== 1'b1) begin failures++; $display("FAIL wrap_idle got=%0d idle=%b exp=0 idle=1", inflight2, idle2); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.a_valid = 1'b0; bus.a_opa = '0; bus.a_opb = '0;
    bus.b_valid = 1'b0; bus.b_opa = '0; bus.b_opb = '0;
    test_reset();
    test_single_a();
    test_back_to_back();
    test_b_only();
    test_gap();
    test_reset_midflight();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpmul_arbiter.md
Name: fpmul_arbiter

Overview:
Two-requester scheduler that shares one pipelined floating-point multiplier instance (FPmul_inreg-class, fixed latency). It accepts operand pairs from requesters A and B through valid/ready handshakes, issues at most one multiply per cycle under round-robin priority, and tags every issued operation. When the product emerges from the multiplier, the block routes it back to the requester that issued it. It sits between the requester logic and the FP_A/FP_B/FP_Z pins of the multiplier.

Parameters:
LAT, 4, clock edges from operand register update to valid FP_Z for the attached multiplier (>=1)
CW, 16, width of per-requester completion counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
a_valid  in  1  requester A has an operand pair
a_opa  in  32  requester A operand 1 (IEEE-754 single)
a_opb  in  32  requester A operand 2
a_ready  out  1  A operand pair accepted this cycle
b_valid  in  1  requester B has an operand pair
b_opa  in  32  requester B operand 1
b_opb  in  32  requester B operand 2
b_ready  out  1  B operand pair accepted this cycle
mul_a  out  32  registered operand to multiplier FP_A
mul_b  out  32  registered operand to multiplier FP_B
mul_z  in  32  multiplier FP_Z
res_data  out  32  product (shared bus), equals mul_z
res_valid_a  out  1  res_data belongs to A this cycle
res_valid_b  out  1  res_data belongs to B this cycle
inflight  out  clog2(LAT+1)  operations issued and not yet returned
idle  out  1  inflight==0
done_cnt_a  out  CW  completed A results
done_cnt_b  out  CW  completed B results

Behaviour:
- Reset: a_ready=b_ready=0 during rst; mul_a=mul_b=0; tag pipeline cleared; res_valid_a=res_valid_b=0; inflight=0; idle=1; done_cnt_*=0; priority pointer = A. Reset mid-operation discards all in-flight operations; their products are never flagged valid.
- Arbitration is combinational within the cycle: grant_A = a_valid & (!b_valid | prio==A); grant_B = b_valid & (!a_valid | prio==B). a_ready=grant_A, b_ready=grant_B, so at most one is high. ready may depend on valid; requesters must hold valid/operands stable until ready.
- Priority pointer: after a grant to X, it moves to the other requester. With no grant, it holds. Only one requester valid: that requester is granted every cycle (full throughput).
- Issue: on a rising edge with grant_X, mul_a/mul_b <= X operands, and a tag {vld=1,id=X} enters stage 1 of a LAT-deep shift register. With no grant, mul_a/mul_b hold and a tag with vld=0 enters.
- Return: a handshake at edge k gives a product on mul_z after edge k+LAT. In that cycle the tag at stage LAT is output: res_valid_X=1 for one cycle, res_data=mul_z. res_data is passed through combinationally and is don't-care when neither valid is high. Results carry no backpressure; requesters must sink them.
- inflight: +1 on issue, -1 on return, unchanged when both occur in the same cycle. Never exceeds LAT.
- done_cnt_X increments on res_valid_X and wraps modulo 2^CW.
- Ordering: results return in issue order. Back-to-back issues produce back-to-back results.

Test Plan:
- Reset, then A alone valid with opa=0x40000000 (2.0) and opb=0x40400000 (3.0) accepted at edge 10, LAT=4 -> a_ready high in cycle 10; res_valid_a high only in the cycle after edge 14; res_data=0x40C00000; done_cnt_a=1; inflight 1->0.
- A and B both valid continuously for 8 cycles after reset -> grants alternate A,B,A,B...; each receives 4 handshakes; returns alternate with the same pattern shifted by LAT; idle=1 after the last return.
- B alone valid for 6 cycles -> b_ready=1 on all 6; 6 consecutive res_valid_b; a_ready stays 0; inflight peaks at 4 (LAT).
- Gap: A issues at edge 5, nothing issues at edges 6-7, B issues at edge 8 -> res_valid_a after edge 9, res_valid_b after edge 12, no valid pulse in between.
- rst asserted for 1 cycle while 3 ops are in flight -> no res_valid pulse afterwards from those ops; inflight=0; idle=1; priority back to A (simultaneous A/B valid next: A granted first).
- done_cnt wrap with CW=2: 5 A results -> done_cnt_a reads 1.
